// File: rtl/decoder_scoreboard_if.sv
// Issue, writeback, query and status signals of decoder_scoreboard.
// The issue/writeback side is the master; the scoreboard is the slave.
interface decoder_scoreboard_if #(
    parameter int ADDR_W = 5
);
    localparam int NREG = 2 ** ADDR_W;

    logic              set_valid;
    logic [ADDR_W-1:0] set_addr;
    logic              clr_valid;
    logic [ADDR_W-1:0] clr_addr;
    logic              flush;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_busy;
    logic              rt_busy;
    logic [NREG-1:0]   set_onehot;
    logic [NREG-1:0]   busy_vec;
    logic              err_dup;
    logic              err_spurious;

    modport master (
        output set_valid, set_addr, clr_valid, clr_addr, flush, rs_addr, rt_addr,
        input  rs_busy, rt_busy, set_onehot, busy_vec, err_dup, err_spurious
    );

    modport slave (
        input  set_valid, set_addr, clr_valid, clr_addr, flush, rs_addr, rt_addr,
        output rs_busy, rt_busy, set_onehot, busy_vec, err_dup, err_spurious
    );
endinterface

// File: rtl/decoder_scoreboard.sv
// One-hot destination decoder plus pending-write scoreboard for the register file.
// Optional macro SCOREBOARD_BYPASS_EN masks hazard queries with the same-cycle writeback.
module decoder_scoreboard #(
    parameter int ADDR_W         = 5,
    parameter bit ZERO_HARDWIRED = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    decoder_scoreboard_if.slave  sb
);
    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] busy_q;
    logic            err_dup_q;
    logic            err_spurious_q;
    logic            dup_hit;
    logic            spurious_hit;
    logic            rs_hit;
    logic            rt_hit;

    // Entry 0 can be hardwired, so its mask bit is dropped in both decodes.
    function automatic logic [NREG-1:0] decode(input logic valid, input logic [ADDR_W-1:0] addr);
        logic [NREG-1:0] mask;
        mask = '0;
        if (valid) begin
            mask[addr] = 1'b1;
        end
        if (ZERO_HARDWIRED) begin
            mask[0] = 1'b0;
        end
        return mask;
    endfunction

    always_comb begin
        set_mask = decode(sb.set_valid, sb.set_addr);
        clr_mask = decode(sb.clr_valid, sb.clr_addr);
    end

    // A matching same-cycle clear/set excuses the duplicate/spurious condition.
    always_comb begin
        dup_hit      = |(set_mask & busy_q & ~clr_mask);
        spurious_hit = |(clr_mask & ~busy_q & ~set_mask);
    end

    always_comb begin
        rs_hit = busy_q[sb.rs_addr];
        rt_hit = busy_q[sb.rt_addr];
        if (ZERO_HARDWIRED && (sb.rs_addr == '0)) begin
            rs_hit = 1'b0;
        end
        if (ZERO_HARDWIRED && (sb.rt_addr == '0)) begin
            rt_hit = 1'b0;
        end
`ifdef SCOREBOARD_BYPASS_EN
        // The regfile forwards writeback data, so a retiring write is no longer a hazard.
        if (sb.clr_valid && (sb.clr_addr == sb.rs_addr)) begin
            rs_hit = 1'b0;
        end
        if (sb.clr_valid && (sb.clr_addr == sb.rt_addr)) begin
            rt_hit = 1'b0;
        end
`endif
    end

    // Set is applied after clear so that the newer writer wins on the same entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q         <= '0;
            err_dup_q      <= 1'b0;
            err_spurious_q <= 1'b0;
        end else if (sb.flush) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
            if (dup_hit) begin
                err_dup_q <= 1'b1;
            end
            if (spurious_hit) begin
                err_spurious_q <= 1'b1;
            end
        end
    end

    assign sb.set_onehot   = set_mask;
    assign sb.busy_vec     = busy_q;
    assign sb.rs_busy      = rs_hit;
    assign sb.rt_busy      = rt_hit;
    assign sb.err_dup      = err_dup_q;
    assign sb.err_spurious = err_spurious_q;
endmodule

// File: tb/tb_decoder_scoreboard.sv
// Scoreboard bench for decoder_scoreboard: directed and random traffic against a
// behavioural register-busy model, plus a short ADDR_W = 3 set/clear run.
module tb_decoder_scoreboard;
    localparam bit ZH = 1'b1;

    typedef struct {
        logic [31:0] onehot;
        logic [31:0] busy;
        logic        rs;
        logic        rt;
        logic        dup;
        logic        spur;
    } exp_t;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    bit model_busy [0:31];
    bit model_dup;
    bit model_spur;

    decoder_scoreboard_if #(.ADDR_W(5)) bus5 ();
    decoder_scoreboard_if #(.ADDR_W(3)) bus3 ();

    decoder_scoreboard #(.ADDR_W(5), .ZERO_HARDWIRED(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (bus5.slave)
    );

    decoder_scoreboard #(.ADDR_W(3), .ZERO_HARDWIRED(1'b1)) dut3 (
        .clk    (clk),
        .resetn (resetn),
        .sb     (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit modelQuery(input int addr, input bit cv, input int ca);
        bit r;
        r = model_busy[addr] && !(ZH && addr == 0);
`ifdef SCOREBOARD_BYPASS_EN
        if (cv && ca == addr) r = 1'b0;
`endif
        return r;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 32; i++) model_busy[i] = 1'b0;
        model_dup  = 1'b0;
        model_spur = 1'b0;
    endfunction

    // Drive one cycle of traffic, record what the DUT must show during it, then advance the model.
    task automatic applyStimulus(input bit sv, input int sa, input bit cv, input int ca,
                                 input bit fl, input int ra, input int rb);
        exp_t e;
        bit   set_ok;
        bit   clr_ok;
        @(negedge clk);
        bus5.set_valid = sv;
        bus5.set_addr  = 5'(sa);
        bus5.clr_valid = cv;
        bus5.clr_addr  = 5'(ca);
        bus5.flush     = fl;
        bus5.rs_addr   = 5'(ra);
        bus5.rt_addr   = 5'(rb);
        set_ok = sv && !(ZH && sa == 0);
        clr_ok = cv && !(ZH && ca == 0);
        e.onehot = '0;
        if (set_ok) e.onehot[sa] = 1'b1;
        for (int i = 0; i < 32; i++) e.busy[i] = model_busy[i];
        e.rs   = modelQuery(ra, cv, ca);
        e.rt   = modelQuery(rb, cv, ca);
        e.dup  = model_dup;
        e.spur = model_spur;
        exp_q.push_back(e);
        if (fl) begin
            for (int i = 0; i < 32; i++) model_busy[i] = 1'b0;
        end else begin
            if (set_ok && model_busy[sa] && !(clr_ok && ca == sa)) model_dup = 1'b1;
            if (clr_ok && !model_busy[ca] && !(set_ok && sa == ca)) model_spur = 1'b1;
            if (clr_ok) model_busy[ca] = 1'b0;
            if (set_ok) model_busy[sa] = 1'b1;
        end
    endtask

    task automatic idleInputs();
        bus5.set_valid = 1'b0;
        bus5.set_addr  = '0;
        bus5.clr_valid = 1'b0;
        bus5.clr_addr  = '0;
        bus5.flush     = 1'b0;
        bus5.rs_addr   = '0;
        bus5.rt_addr   = '0;
    endtask

    // Reset lands between clock edges, so clearing is visible before any edge.
    task automatic resetMidRun();
        @(negedge clk);
        idleInputs();
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_reset_busy_vec", bus5.busy_vec, 32'h0);
        checkOutput("async_reset_err_dup", 32'(bus5.err_dup), 32'h0);
        checkOutput("async_reset_err_spurious", 32'(bus5.err_spurious), 32'h0);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        modelReset();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("set_onehot", bus5.set_onehot, e.onehot);
                checkOutput("busy_vec", bus5.busy_vec, e.busy);
                checkOutput("rs_busy", 32'(bus5.rs_busy), 32'(e.rs));
                checkOutput("rt_busy", 32'(bus5.rt_busy), 32'(e.rt));
                checkOutput("err_dup", 32'(bus5.err_dup), 32'(e.dup));
                checkOutput("err_spurious", 32'(bus5.err_spurious), 32'(e.spur));
            end
        end
    end

    initial begin
        bit exp_rs3;
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        idleInputs();
        bus3.set_valid = 1'b0;
        bus3.set_addr  = '0;
        bus3.clr_valid = 1'b0;
        bus3.clr_addr  = '0;
        bus3.flush     = 1'b0;
        bus3.rs_addr   = '0;
        bus3.rt_addr   = '0;
        modelReset();
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 5, 5);
        // Set 5, observe it, clear it, observe the clear.
        applyStimulus(1, 5, 0, 0, 0, 5, 6);
        applyStimulus(0, 0, 0, 0, 0, 5, 5);
        applyStimulus(0, 0, 1, 5, 0, 5, 5);
        applyStimulus(0, 0, 0, 0, 0, 5, 0);
        // Zero register is never busy and never flags.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        // Same-cycle conflicts.
        applyStimulus(1, 7, 0, 0, 0, 7, 9);
        applyStimulus(1, 7, 1, 7, 0, 7, 9);
        applyStimulus(1, 9, 1, 7, 0, 7, 9);
        applyStimulus(0, 0, 0, 0, 0, 7, 9);
        // Duplicate set and spurious clear, both sticky.
        applyStimulus(1, 3, 0, 0, 0, 3, 3);
        applyStimulus(1, 3, 0, 0, 0, 3, 3);
        applyStimulus(0, 0, 1, 12, 0, 12, 3);
        applyStimulus(0, 0, 0, 0, 0, 12, 3);
        applyStimulus(0, 0, 1, 3, 0, 3, 12);
        applyStimulus(1, 20, 0, 0, 0, 20, 9);
        applyStimulus(0, 0, 0, 0, 0, 20, 9);
        resetMidRun();
        // Flush discards pending writes and suppresses errors it would otherwise raise.
        applyStimulus(1, 1, 0, 0, 0, 1, 2);
        applyStimulus(1, 2, 0, 0, 0, 1, 2);
        applyStimulus(1, 31, 0, 0, 0, 31, 2);
        applyStimulus(1, 1, 1, 5, 1, 1, 31);
        applyStimulus(1, 4, 0, 0, 1, 4, 31);
        applyStimulus(0, 0, 0, 0, 0, 4, 1);

        for (int n = 0; n < 500; n++) begin
            int sa, ca, ra, rb;
            sa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            ca = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? ca : int'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), sa, 1'($urandom_range(0, 1)), ca,
                          ($urandom_range(0, 31) == 0), ra, rb);
            if (n == 250) resetMidRun();
        end

        @(negedge clk);
        idleInputs();
        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        // Narrow build: busy_vec is 8 bits wide.
        @(negedge clk);
        bus3.set_valid = 1'b1;
        bus3.set_addr  = 3'd5;
        bus3.rs_addr   = 3'd5;
        #2;
        checkOutput("w3_set_onehot", 32'(bus3.set_onehot), 32'h20);
        checkOutput("w3_rs_before_set", 32'(bus3.rs_busy), 32'h0);
        @(negedge clk);
        bus3.set_valid = 1'b0;
        #2;
        checkOutput("w3_busy_after_set", 32'(bus3.busy_vec), 32'h20);
        checkOutput("w3_rs_after_set", 32'(bus3.rs_busy), 32'h1);
        @(negedge clk);
        bus3.clr_valid = 1'b1;
        bus3.clr_addr  = 3'd5;
        #2;
`ifdef SCOREBOARD_BYPASS_EN
        exp_rs3 = 1'b0;
`else
        exp_rs3 = 1'b1;
`endif
        checkOutput("w3_rs_clear_cycle", 32'(bus3.rs_busy), 32'(exp_rs3));
        @(negedge clk);
        bus3.clr_valid = 1'b0;
        #2;
        checkOutput("w3_busy_after_clear", 32'(bus3.busy_vec), 32'h0);
        checkOutput("w3_rs_after_clear", 32'(bus3.rs_busy), 32'h0);
        checkOutput("w3_err_spurious", 32'(bus3.err_spurious), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decoder_scoreboard.md
# decoder_scoreboard

Parametrised one-hot destination decoder with a registered pending-write scoreboard for the register file. It decodes issue-stage destination addresses into one-hot set masks and writeback addresses into one-hot clear masks, and keeps a busy bit per register. It answers two source-operand hazard queries per cycle. It sits between decode/issue and writeback and drives the issue-stage stall logic.

## Interface
Parameters:
- `ADDR_W`, 5: register address width; entry count `NREG = 2**ADDR_W`.
- `ZERO_HARDWIRED`, 1: when 1, entry 0 is never busy and never flags errors.

Ports (`clk` and `resetn` are the codebase's clock and reset names):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `set_valid`  in  1  an issued instruction writes `set_addr`.
- `set_addr`  in  ADDR_W  destination register of the issuing instruction.
- `clr_valid`  in  1  writeback retires a write to `clr_addr`.
- `clr_addr`  in  ADDR_W  writeback destination register.
- `flush`  in  1  pipeline flush; discards all pending writes.
- `rs_addr`  in  ADDR_W  source operand A query address.
- `rt_addr`  in  ADDR_W  source operand B query address.
- `rs_busy`  out  1  source A has a pending write.
- `rt_busy`  out  1  source B has a pending write.
- `set_onehot`  out  NREG  combinational decode of `set_addr`, gated by `set_valid`.
- `busy_vec`  out  NREG  registered busy bits.
- `err_dup`  out  1  sticky flag: set issued to an entry that is already busy.
- `err_spurious`  out  1  sticky flag: clear issued to an entry that is not busy.

## Operation
Decode:
- `set_onehot[i] = set_valid && (set_addr == i)`.
- The clear mask is the same internal decode of `clr_addr` gated by `clr_valid`.
- When `ZERO_HARDWIRED` is 1, bit 0 of both masks is forced to 0.

Busy update, per entry i, evaluated in this priority order:
1. `flush` → 0.
2. Set mask bit i → 1. Set wins over a same-cycle clear of the same entry, because the newer writer must be tracked.
3. Clear mask bit i → 0.
4. Otherwise hold.

Queries:
- `rs_busy = busy_vec[rs_addr]`, `rt_busy = busy_vec[rt_addr]`.
- With `ZERO_HARDWIRED`, queries to entry 0 always return 0.

Error flags:
- `err_dup` sets when a set hits an entry with `busy_vec` = 1 and there is no same-cycle clear of that entry.
- `err_spurious` sets when a clear hits an entry with `busy_vec` = 0 and there is no same-cycle set of that entry.
- Neither flag updates in a cycle with `flush` asserted.
- Both flags are sticky and are cleared only by reset.

## Timing
- Reset (`resetn` low, asynchronous): `busy_vec` = 0, `err_dup` = 0, `err_spurious` = 0. Consequently `rs_busy` and `rt_busy` read 0.
- `set_onehot` has zero-cycle latency (combinational).
- A set in cycle N makes `busy_vec` and the queries read 1 from cycle N+1.
- A clear in cycle N makes them read 0 from cycle N+1, unless bypass is compiled in (see Configuration).
- Flush in cycle N: all entries read 0 from cycle N+1; a set in cycle N is discarded.
- Same-cycle set and clear on different entries: both take effect.
- Same-cycle set and clear on the same entry: entry ends at 1 and no error is flagged.
- `rs_addr == rt_addr`: both outputs are identical.
- Deassertion of `resetn` is synchronised externally; the first update is on the first rising edge with `resetn` high.

## Configuration
Macro `SCOREBOARD_BYPASS_EN`:
- Defined: the queries are masked by the same-cycle clear. `rs_busy = busy_vec[rs_addr] && !(clr_valid && clr_addr == rs_addr)`, and likewise `rt_busy`. A consumer therefore does not stall in the writeback cycle when the regfile forwards the write data.
- Not defined: the queries reflect `busy_vec` only, and clears become visible one cycle later.
- The `busy_vec` update rules are identical in both builds.

## Test plan
- Reset then idle: after `resetn` rises, `busy_vec` = 0 and all flags are 0. Asserting `resetn` low mid-run with entries busy clears them immediately, without waiting for a clock edge.
- Set then clear:
  - Set 5 in cycle 1 → `set_onehot` = 32'h20 in cycle 1; `rs_addr` = 5 gives `rs_busy` = 1 in cycle 2.
  - Clear 5 in cycle 3 → without bypass, `rs_busy` = 1 in cycle 3 and 0 in cycle 4; with bypass, `rs_busy` = 0 already in cycle 3.
- Zero register: set 0 → `set_onehot` = 0, `busy_vec` stays 0, and a query on 0 returns 0. Clearing 0 does not raise `err_spurious`.
- Same-cycle conflict:
  - With 7 busy, set 7 and clear 7 together → `busy_vec[7]` = 1 and no error.
  - Set 9 and clear 7 together → `busy_vec[9]` = 1 and `busy_vec[7]` = 0.
- Errors:
  - Set 3 twice without a clear → `err_dup` = 1 and stays 1.
  - Clear 12 while it is idle → `err_spurious` = 1; only reset clears it.
- Flush: with entries 1, 2 and 31 busy, flush together with set 4 → `busy_vec` = 0 next cycle and no error flags change. A parametrised `ADDR_W` = 3 run repeats the set/clear scenario with `busy_vec` 8 bits wide.
